// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator stage.
package booth_pkg;

  localparam int PW_DEF = 16;
  localparam int LIM_W  = 64;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Largest positive value of an aw-bit signed number, zero-extended to LIM_W.
  function automatic logic [LIM_W-1:0] sat_max(input int aw);
    sat_max = (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  function automatic logic [LIM_W-1:0] sat_min(input int aw);
    sat_min = ~sat_max(aw);
  endfunction

endpackage

// File: rtl/booth_mac_acc_sat_add.sv
// AW-bit signed adder with overflow flag; clamps to the signed limits
// only when BOOTH_MAC_SAT_EN is defined, otherwise wraps modulo 2^AW.
module sat_add
  import booth_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW-1:0] raw_s;

`ifdef BOOTH_MAC_SAT_EN
  localparam logic [AW-1:0] MAX_L = AW'(sat_max(AW));
  localparam logic [AW-1:0] MIN_L = AW'(sat_min(AW));
`endif

  assign raw_s = a + b;

  // Overflow when both operands share a sign that the raw sum does not.
  always_comb begin
    ovf = (a[AW-1] == b[AW-1]) && (raw_s[AW-1] != a[AW-1]);
`ifdef BOOTH_MAC_SAT_EN
    if (ovf) begin
      sum = a[AW-1] ? MIN_L : MAX_L;
    end else begin
      sum = raw_s;
    end
`else
    sum = raw_s;
`endif
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Accumulates N_TERMS signed Booth products and hands the sum downstream.
// Build option BOOTH_MAC_SAT_EN selects saturating instead of wrapping sums.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int AW      = 24,
  parameter int N_TERMS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prod_valid,
  input  logic [PW-1:0] prod,
  output logic          prod_ready,
  input  logic          acc_clr,
  output logic          res_valid,
  output logic [AW-1:0] res_data,
  input  logic          res_ready,
  output logic [7:0]    term_cnt,
  output logic          ovf
);

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_data_q, res_data_d;

  logic [AW-1:0] prod_ext_s;
  logic [AW-1:0] base_acc_s;
  logic [7:0]    base_cnt_s;
  logic          base_ovf_s;
  logic [AW-1:0] sum_s;
  logic          add_ovf_s;

  assign prod_ext_s = AW'($signed(prod));

  // Group state as seen by this cycle's product: a clear wipes it first.
  always_comb begin
    base_acc_s = acc_q;
    base_cnt_s = cnt_q;
    base_ovf_s = ovf_q;
    if (acc_clr) begin
      base_acc_s = {AW{1'b0}};
      base_cnt_s = 8'd0;
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_q;
      base_cnt_s = cnt_q;
      base_ovf_s = ovf_q;
    end
  end

  sat_add #(.AW(AW)) u_add (
    .a   (base_acc_s),
    .b   (prod_ext_s),
    .sum (sum_s),
    .ovf (add_ovf_s)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      ACCUM: begin
        acc_d = base_acc_s;
        cnt_d = base_cnt_s;
        ovf_d = base_ovf_s;
        if (prod_valid) begin
          acc_d = sum_s;
          cnt_d = base_cnt_s + 8'd1;
          ovf_d = base_ovf_s | add_ovf_s;
          if (base_cnt_s == LAST_CNT) begin
            res_data_d  = sum_s;
            res_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      // Result and sticky flag stay frozen until the consumer takes them.
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          acc_d       = {AW{1'b0}};
          cnt_d       = 8'd0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = ACCUM;
        acc_d       = {AW{1'b0}};
        cnt_d       = 8'd0;
        ovf_d       = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= {AW{1'b0}};
      cnt_q       <= 8'd0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign term_cnt   = cnt_q;
  assign ovf        = ovf_q;

endmodule
